wb_coef_calc: RTL and testbench

// Coefficient engine for the white balance corrector, directly downstream of the
// WB CSR block: consumes mode/cal_stb/man_sel/man_coef/man_lock, feeds cur_coef back.

---
 rtl/wb_coef_calc.sv | 164 ++++++++++++++++
 tb/tb_wb_coef_calc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_coef_calc.sv
// wb_coef_calc: gray-world white balance gain engine with manual override and registered gain select.
module wb_coef_calc #(
    parameter int PX_WIDTH    = 10,
    parameter int FRAME_RES_Y = 1080,
    parameter int MAX_PIXELS  = 2073600,
    parameter int COEF_W      = 16,
    parameter int COEF_FRAC   = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  px_tvalid_i,
    input  logic                  px_tready_i,
    input  logic [3*PX_WIDTH-1:0] px_tdata_i,
    input  logic                  px_tuser_i,
    input  logic                  px_tlast_i,
    input  logic [1:0]            mode_i,
    input  logic                  cal_stb_i,
    input  logic [1:0]            man_sel_i,
    input  logic [31:0]           man_coef_i,
    input  logic                  man_lock_i,
    output logic [COEF_W-1:0]     coef_r_o,
    output logic [COEF_W-1:0]     coef_g_o,
    output logic [COEF_W-1:0]     coef_b_o,
    output logic                  coef_valid_o,
    output logic [31:0]           cur_coef_o,
    output logic                  busy_o
);
    localparam int ACC_W = PX_WIDTH + $clog2(MAX_PIXELS);
    localparam int REM_W = ACC_W + COEF_W;
    localparam int LN_W  = $clog2(FRAME_RES_Y + 1);
    localparam int CNT_W = $clog2(COEF_W + 1);
    localparam logic [COEF_W-1:0] ONE = COEF_W'(1 << COEF_FRAC);

    typedef enum logic [2:0] {IDLE, WAIT_SOF, ACCUM, DIV_R, DIV_B, APPLY} state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   sum_r_q, sum_g_q, sum_b_q;
    logic [LN_W-1:0]    lines_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [REM_W-1:0]   rem_q, dvs_q;
    logic [COEF_W-1:0]  quo_q, q_r_q, q_b_q;
    logic               ovf_q, lock_q;
    logic [COEF_W-1:0]  auto_r_q, auto_b_q, man_r_q, man_g_q, man_b_q;
    logic [COEF_W-1:0]  auto_r_d, auto_b_d, quo_nx, quo_fin;
    logic [ACC_W-1:0]   px_r, px_g, px_b, divisor;
    logic [REM_W-1:0]   dividend;
    logic [LN_W-1:0]    lines_b;
    logic               beat, apply_ok, ovf_ld, ge, unused_bits;

    assign unused_bits = ^man_coef_i[31:COEF_W];
    assign beat     = px_tvalid_i && px_tready_i;
    assign px_r     = ACC_W'(px_tdata_i[3*PX_WIDTH-1:2*PX_WIDTH]);
    assign px_g     = ACC_W'(px_tdata_i[2*PX_WIDTH-1:PX_WIDTH]);
    assign px_b     = ACC_W'(px_tdata_i[PX_WIDTH-1:0]);
    assign lines_b  = px_tuser_i ? '0 : lines_q;
    assign divisor  = (state_q == DIV_R) ? sum_r_q : sum_b_q;
    assign dividend = REM_W'({sum_g_q, {COEF_FRAC{1'b0}}});
    assign ovf_ld   = (divisor == '0) || (dividend >= (REM_W'(divisor) << COEF_W));
    assign ge       = rem_q >= dvs_q;
    assign quo_nx   = {quo_q[COEF_W-2:0], ge};
    assign quo_fin  = ovf_q ? '1 : quo_nx;
    // auto gains must be visible to the output select on the same edge they load
    assign apply_ok = (state_q == APPLY) && mode_i[1];
    assign auto_r_d = apply_ok ? q_r_q : auto_r_q;
    assign auto_b_d = apply_ok ? q_b_q : auto_b_q;
    assign busy_o   = state_q != IDLE;
    assign cur_coef_o = (man_sel_i == 2'd0) ? 32'(coef_r_o) :
                        (man_sel_i == 2'd1) ? 32'(coef_g_o) :
                        (man_sel_i == 2'd2) ? 32'(coef_b_o) : 32'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            sum_r_q      <= '0;
            sum_g_q      <= '0;
            sum_b_q      <= '0;
            lines_q      <= '0;
            cnt_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            quo_q        <= '0;
            ovf_q        <= 1'b0;
            q_r_q        <= '0;
            q_b_q        <= '0;
            auto_r_q     <= ONE;
            auto_b_q     <= ONE;
            coef_valid_o <= 1'b0;
        end else begin
            coef_valid_o <= apply_ok;
            auto_r_q     <= auto_r_d;
            auto_b_q     <= auto_b_d;
            if (state_q != IDLE && !mode_i[1]) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (mode_i == 2'd2 || (mode_i == 2'd3 && cal_stb_i)) state_q <= WAIT_SOF;
                    WAIT_SOF: if (beat && px_tuser_i) begin
                        sum_r_q <= px_r;
                        sum_g_q <= px_g;
                        sum_b_q <= px_b;
                        lines_q <= LN_W'(px_tlast_i);
                        state_q <= ACCUM;
                    end
                    ACCUM: if (beat) begin
                        sum_r_q <= (px_tuser_i ? '0 : sum_r_q) + px_r;
                        sum_g_q <= (px_tuser_i ? '0 : sum_g_q) + px_g;
                        sum_b_q <= (px_tuser_i ? '0 : sum_b_q) + px_b;
                        lines_q <= lines_b + LN_W'(px_tlast_i);
                        if (px_tlast_i && lines_b == LN_W'(FRAME_RES_Y - 1)) begin
                            cnt_q   <= '0;
                            state_q <= DIV_R;
                        end
                    end
                    DIV_R, DIV_B: if (cnt_q == '0) begin
                        rem_q <= dividend;
                        dvs_q <= REM_W'(divisor) << (COEF_W - 1);
                        ovf_q <= ovf_ld;
                        quo_q <= '0;
                        cnt_q <= CNT_W'(1);
                    end else begin
                        if (ge) rem_q <= rem_q - dvs_q;
                        dvs_q <= dvs_q >> 1;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(COEF_W)) begin
                            cnt_q <= '0;
                            if (state_q == DIV_R) begin
                                q_r_q   <= quo_fin;
                                state_q <= DIV_B;
                            end else begin
                                q_b_q   <= quo_fin;
                                state_q <= APPLY;
                            end
                        end
                    end
                    APPLY: state_q <= (mode_i == 2'd2) ? WAIT_SOF : IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q   <= 1'b0;
            man_r_q  <= ONE;
            man_g_q  <= ONE;
            man_b_q  <= ONE;
            coef_r_o <= ONE;
            coef_g_o <= ONE;
            coef_b_o <= ONE;
        end else begin
            lock_q <= man_lock_i;
            if (man_lock_i && !lock_q) begin
                if (man_sel_i == 2'd0) man_r_q <= man_coef_i[COEF_W-1:0];
                if (man_sel_i == 2'd1) man_g_q <= man_coef_i[COEF_W-1:0];
                if (man_sel_i == 2'd2) man_b_q <= man_coef_i[COEF_W-1:0];
            end
            coef_r_o <= (mode_i == 2'd0) ? ONE : (mode_i == 2'd1) ? man_r_q : auto_r_d;
            coef_g_o <= (mode_i == 2'd1) ? man_g_q : ONE;
            coef_b_o <= (mode_i == 2'd0) ? ONE : (mode_i == 2'd1) ? man_b_q : auto_b_d;
        end
    end
endmodule

// File: tb/tb_wb_coef_calc.sv
// tb_wb_coef_calc: directed vectors for the white balance gain engine (4-line, 4-pixel frames).
module tb_wb_coef_calc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        px_tvalid = 1'b0, px_tready = 1'b0, px_tuser = 1'b0, px_tlast = 1'b0;
    logic [29:0] px_tdata = '0;
    logic [1:0]  mode = 2'd0, man_sel = 2'd0;
    logic        cal_stb = 1'b0, man_lock = 1'b0;
    logic [31:0] man_coef = '0;
    logic [15:0] coef_r, coef_g, coef_b;
    logic        coef_valid, busy;
    logic [31:0] cur_coef;
    int          n_vec = 0, n_err = 0, n_valid = 0, lat, base;

    wb_coef_calc #(.FRAME_RES_Y(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .px_tvalid_i(px_tvalid), .px_tready_i(px_tready), .px_tdata_i(px_tdata),
        .px_tuser_i(px_tuser), .px_tlast_i(px_tlast),
        .mode_i(mode), .cal_stb_i(cal_stb), .man_sel_i(man_sel),
        .man_coef_i(man_coef), .man_lock_i(man_lock),
        .coef_r_o(coef_r), .coef_g_o(coef_g), .coef_b_o(coef_b),
        .coef_valid_o(coef_valid), .cur_coef_o(cur_coef), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (coef_valid) n_valid++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cal();
        mode = 2'd3;
        cal_stb = 1'b1;
        tick(1);
        cal_stb = 1'b0;
    endtask

    // non-beat cycles carry junk flags that must be ignored
    task automatic send_px(input logic [9:0] r, g, b, input int nlines, input bit gaps);
        for (int y = 0; y < nlines; y++)
            for (int x = 0; x < 4; x++) begin
                if (gaps)
                    for (int k = $urandom_range(0, 2); k > 0; k--) begin
                        px_tvalid = $urandom_range(0, 1) == 1;
                        px_tready = !px_tvalid;
                        px_tdata = 30'h3FFFFFFF;
                        px_tuser = 1'b1;
                        px_tlast = 1'b1;
                        tick(1);
                    end
                px_tvalid = 1'b1;
                px_tready = 1'b1;
                px_tdata = {r, g, b};
                px_tuser = (x == 0 && y == 0);
                px_tlast = (x == 3);
                tick(1);
            end
        px_tvalid = 1'b0;
        px_tuser = 1'b0;
        px_tlast = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = -1;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if (coef_valid) begin
                l = i;
                break;
            end
        end
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_r", 32'(coef_r), 32'h1000);
        check("rst_g", 32'(coef_g), 32'h1000);
        check("rst_b", 32'(coef_b), 32'h1000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur", cur_coef, 32'h1000);
        check("rst_valid", 32'(coef_valid), 32'd0);

        mode = 2'd1;
        man_coef = 32'hABCD_2000;
        man_lock = 1'b1;
        tick(2);
        check("man_r", 32'(coef_r), 32'h2000);
        check("man_cur", cur_coef, 32'h2000);
        man_lock = 1'b0;
        man_sel = 2'd2;
        man_coef = 32'h0000_0123;
        tick(1);
        man_lock = 1'b1;
        tick(2);
        check("man_b", 32'(coef_b), 32'h0123);
        check("man_r_kept", 32'(coef_r), 32'h2000);
        man_sel = 2'd3;
        #1;
        check("cur_none", cur_coef, 32'd0);
        man_lock = 1'b0;
        mode = 2'd0;
        tick(2);
        check("byp_r", 32'(coef_r), 32'h1000);
        check("byp_b", 32'(coef_b), 32'h1000);

        cal();
        check("busy_wait", 32'(busy), 32'd1);
        base = n_valid;
        send_px(10'd100, 10'd200, 10'd400, 4, 1'b0);
        wait_valid(lat);
        check("lat", 32'(lat), 32'd35);
        check("gw_r", 32'(coef_r), 32'h2000);
        check("gw_g", 32'(coef_g), 32'h1000);
        check("gw_b", 32'(coef_b), 32'h0800);
        man_sel = 2'd2;
        #1;
        check("gw_cur_b", cur_coef, 32'h0800);
        tick(1);
        check("valid_pulse", 32'(coef_valid), 32'd0);
        check("busy_done", 32'(busy), 32'd0);
        check("nvalid_1", 32'(n_valid - base), 32'd1);

        cal();
        send_px(10'd0, 10'd50, 10'd50, 4, 1'b0);
        wait_valid(lat);
        check("r0_r", 32'(coef_r), 32'hFFFF);
        check("r0_b", 32'(coef_b), 32'h1000);
        cal();
        send_px(10'd10, 10'd0, 10'd10, 4, 1'b0);
        wait_valid(lat);
        check("g0_r", 32'(coef_r), 32'h0000);
        check("g0_b", 32'(coef_b), 32'h0000);
        cal();
        send_px(10'd10, 10'd160, 10'd20, 4, 1'b0);
        wait_valid(lat);
        check("ovf16_r", 32'(coef_r), 32'hFFFF);
        check("ovf16_b", 32'(coef_b), 32'h8000);
        cal();
        send_px(10'd11, 10'd160, 10'd30, 4, 1'b0);
        wait_valid(lat);
        check("trunc_r", 32'(coef_r), 32'hE8BA);
        check("trunc_b", 32'(coef_b), 32'h5555);

        cal();
        send_px(10'd300, 10'd300, 10'd300, 2, 1'b0);
        send_px(10'd200, 10'd100, 10'd50, 4, 1'b0);
        wait_valid(lat);
        check("restart_lat", 32'(lat), 32'd35);
        check("restart_r", 32'(coef_r), 32'h0800);
        check("restart_b", 32'(coef_b), 32'h2000);

        cal();
        base = n_valid;
        send_px(10'd7, 10'd7, 10'd7, 2, 1'b0);
        check("abort_busy_pre", 32'(busy), 32'd1);
        mode = 2'd0;
        tick(1);
        check("abort_busy", 32'(busy), 32'd0);
        mode = 2'd3;
        tick(40);
        check("abort_r", 32'(coef_r), 32'h0800);
        check("abort_b", 32'(coef_b), 32'h2000);
        check("abort_novalid", 32'(n_valid - base), 32'd0);

        mode = 2'd2;
        base = n_valid;
        send_px(10'd100, 10'd200, 10'd400, 4, 1'b1);
        wait_valid(lat);
        check("c1_lat", 32'(lat), 32'd35);
        check("c1_r", 32'(coef_r), 32'h2000);
        check("c1_b", 32'(coef_b), 32'h0800);
        send_px(10'd400, 10'd200, 10'd100, 4, 1'b1);
        wait_valid(lat);
        check("c2_r", 32'(coef_r), 32'h0800);
        check("c2_b", 32'(coef_b), 32'h2000);
        send_px(10'd50, 10'd150, 10'd120, 4, 1'b1);
        wait_valid(lat);
        check("c3_r", 32'(coef_r), 32'h3000);
        check("c3_b", 32'(coef_b), 32'h1400);
        check("c3_busy", 32'(busy), 32'd1);
        tick(2);
        check("c_nvalid", 32'(n_valid - base), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
